// File: rtl/uart_fifo_if.sv
// Stream side of uart_fifo: RX FIFO head/pop and TX FIFO push, plus status pulses.
// valid/ready: a word moves on a rising clk edge where valid && ready; the valid side holds its data stable until then.
interface uart_fifo_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_perr;
  logic                 rx_ferr;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_overrun;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_idle;

  modport master (
    output rx_data, rx_perr, rx_ferr, rx_valid, rx_overrun, tx_ready, tx_idle,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_perr, rx_ferr, rx_valid, rx_overrun, tx_ready, tx_idle,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_fifo.sv
// Full-duplex UART with configurable frame, run-time baud divisor and RX/TX FIFOs.
// rx_state/tx_state expose the FSMs: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP.
module uart_fifo #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 1000000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int FILT_CYC   = (CLK_HZ / BAUD) / 4
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic [15:0] baud_div,
  input  logic        rxd,
  output logic        txd,
  uart_fifo_if.master bus,
  output logic [2:0]  rx_state,
  output logic [2:0]  tx_state
);
  localparam int   DEF_DIV   = CLK_HZ / BAUD;
  localparam int   AW        = $clog2(FIFO_DEPTH);
  localparam int   RW        = DATA_BITS + 2;
  localparam logic ODD       = (PARITY == 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
  } state_t;

  logic [15:0] eff_div;
  always_comb begin
    eff_div = baud_div;
    if (baud_div == 16'd0)     eff_div = 16'(DEF_DIV);
    else if (baud_div < 16'd4) eff_div = 16'd4;
  end

  // ---------------- RX line: synchroniser and glitch filter ----------------
  logic [1:0]  rx_sync;
  logic        rx_filt, rx_prev;
  logic [15:0] filt_cnt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rx_sync  <= 2'b11;
      rx_filt  <= 1'b1;
      rx_prev  <= 1'b1;
      filt_cnt <= 16'd0;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      rx_prev <= rx_filt;
      if (FILT_CYC == 0) begin
        rx_filt <= rx_sync[1];
      end else if (rx_sync[1] == rx_filt) begin
        filt_cnt <= 16'd0;
      end else if (filt_cnt == 16'(FILT_CYC - 1)) begin
        rx_filt  <= rx_sync[1];
        filt_cnt <= 16'd0;
      end else begin
        filt_cnt <= filt_cnt + 16'd1;
      end
    end
  end

  // ---------------- RX FSM ----------------
  state_t                rx_st;
  logic [15:0]           rx_div, rx_cnt;
  logic [3:0]            rx_bit;
  logic                  rx_stop, rx_perr_q, rx_ferr_q, push_v;
  logic [DATA_BITS-1:0]  rx_sh;
  logic [RW-1:0]         push_word;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rx_st     <= S_IDLE;
      rx_div    <= 16'd0;
      rx_cnt    <= 16'd0;
      rx_bit    <= 4'd0;
      rx_stop   <= 1'b0;
      rx_perr_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      rx_sh     <= '0;
      push_v    <= 1'b0;
      push_word <= '0;
    end else begin
      push_v <= 1'b0;
      if (rx_st == S_IDLE) begin
        if (rx_prev && !rx_filt) begin
          rx_div    <= eff_div;
          rx_cnt    <= eff_div >> 1;
          rx_perr_q <= 1'b0;
          rx_ferr_q <= 1'b0;
          rx_st     <= S_START;
        end
      end else if (rx_cnt != 16'd0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt <= rx_div - 16'd1;
        case (rx_st)
          S_START: begin
            rx_bit <= 4'd0;
            rx_st  <= rx_filt ? S_IDLE : S_DATA;
          end
          S_DATA: begin
            rx_sh <= {rx_filt, rx_sh[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) begin
              rx_stop <= 1'b0;
              rx_st   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              rx_bit <= rx_bit + 4'd1;
            end
          end
          S_PARITY: begin
            rx_perr_q <= (^rx_sh) ^ rx_filt ^ ODD;
            rx_stop   <= 1'b0;
            rx_st     <= S_STOP;
          end
          S_STOP: begin
            if (!rx_filt) rx_ferr_q <= 1'b1;
            if (rx_stop == LAST_STOP) begin
              push_v    <= 1'b1;
              push_word <= {rx_perr_q, rx_ferr_q | ~rx_filt, rx_sh};
              rx_st     <= S_IDLE;
            end else begin
              rx_stop <= 1'b1;
            end
          end
          default: rx_st <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX FIFO (first-word fall-through) ----------------
  logic [RW-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]   rx_wr, rx_rd;
  logic [RW-1:0] rx_head;
  logic          rx_full, rx_pop, rx_wr_en, ovr_q;

  assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign rx_pop   = bus.rx_valid && bus.rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign rx_wr_en = push_v && (!rx_full || rx_pop);
  assign rx_head  = rx_mem[rx_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_wr_en) rx_mem[rx_wr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rx_wr <= '0;
      rx_rd <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (rx_wr_en) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)   rx_rd <= rx_rd + 1'b1;
      ovr_q <= push_v && rx_full && !rx_pop;
    end
  end

  assign bus.rx_valid   = (rx_wr != rx_rd);
  assign bus.rx_data    = rx_head[DATA_BITS-1:0];
  assign bus.rx_ferr    = rx_head[DATA_BITS];
  assign bus.rx_perr    = rx_head[DATA_BITS+1];
  assign bus.rx_overrun = ovr_q;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wr, tx_rd;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_full, tx_empty, tx_push, tx_load;

  assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_push  = bus.tx_valid && bus.tx_ready;
  assign tx_head  = tx_mem[tx_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= bus.tx_data;
  end

  // ---------------- TX FSM ----------------
  state_t               tx_st;
  logic [15:0]          tx_div, tx_cnt;
  logic [3:0]           tx_bit;
  logic                 tx_stop, tx_par, txd_q;
  logic [DATA_BITS-1:0] tx_sh;

  // Load from IDLE, or straight from the last stop period for back-to-back frames.
  always_comb begin
    tx_load = 1'b0;
    if (!tx_empty) begin
      if (tx_st == S_IDLE) tx_load = 1'b1;
      else if (tx_st == S_STOP && tx_cnt == 16'd0 && tx_stop == LAST_STOP) tx_load = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      tx_st   <= S_IDLE;
      tx_div  <= 16'd0;
      tx_cnt  <= 16'd0;
      tx_bit  <= 4'd0;
      tx_stop <= 1'b0;
      tx_par  <= 1'b0;
      tx_sh   <= '0;
      txd_q   <= 1'b1;
      tx_wr   <= '0;
      tx_rd   <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_load) tx_rd <= tx_rd + 1'b1;
      // txd follows the state one cycle later, so every bit keeps a full D cycles.
      case (tx_st)
        S_START:  txd_q <= 1'b0;
        S_DATA:   txd_q <= tx_sh[0];
        S_PARITY: txd_q <= tx_par;
        default:  txd_q <= 1'b1;
      endcase
      if (tx_load) begin
        tx_sh  <= tx_head;
        tx_par <= (^tx_head) ^ ODD;
        tx_div <= eff_div;
        tx_cnt <= eff_div - 16'd1;
        tx_st  <= S_START;
      end else if (tx_st != S_IDLE) begin
        if (tx_cnt != 16'd0) begin
          tx_cnt <= tx_cnt - 16'd1;
        end else begin
          tx_cnt <= tx_div - 16'd1;
          case (tx_st)
            S_START: begin
              tx_bit <= 4'd0;
              tx_st  <= S_DATA;
            end
            S_DATA: begin
              tx_sh <= tx_sh >> 1;
              if (tx_bit == LAST_BIT) begin
                tx_stop <= 1'b0;
                tx_st   <= (PARITY != 0) ? S_PARITY : S_STOP;
              end else begin
                tx_bit <= tx_bit + 4'd1;
              end
            end
            S_PARITY: begin
              tx_stop <= 1'b0;
              tx_st   <= S_STOP;
            end
            S_STOP: begin
              if (tx_stop == LAST_STOP) tx_st <= S_IDLE;
              else tx_stop <= 1'b1;
            end
            default: tx_st <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign txd          = txd_q;
  assign bus.tx_ready = !tx_full;
  assign bus.tx_idle  = (tx_st == S_IDLE) && tx_empty;
  assign rx_state     = rx_st;
  assign tx_state     = tx_st;
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: TX timing, parity/stop loopback, error flags,
// overrun, glitch filter and asynchronous reset mid-frame.
module tb_uart_fifo;
  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic [15:0] baud_div_a, baud_div_b;
  logic        rxd_a, txd_a, rxd_b, rxd_b_drv, txd_b, loop_b;
  logic [2:0]  rx_state_a, tx_state_a, rx_state_b, tx_state_b;

  always #5 clk = ~clk;

  uart_fifo_if #(.DATA_BITS(8)) if_a ();
  uart_fifo_if #(.DATA_BITS(8)) if_b ();

  assign rxd_b = loop_b ? txd_b : rxd_b_drv;

  uart_fifo dut_a (
    .clk(clk), .rst_(rst_), .baud_div(baud_div_a), .rxd(rxd_a), .txd(txd_a),
    .bus(if_a.master), .rx_state(rx_state_a), .tx_state(tx_state_a)
  );

  uart_fifo #(.PARITY(2), .STOP_BITS(2), .FILT_CYC(4)) dut_b (
    .clk(clk), .rst_(rst_), .baud_div(baud_div_b), .rxd(rxd_b), .txd(txd_b),
    .bus(if_b.master), .rx_state(rx_state_b), .tx_state(tx_state_b)
  );

  // ---------------- scoreboard counters and monitors ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int a_nonidle = 0, a_start = 0, a_data = 0, a_txd_low = 0, b_ovr = 0;
  int b_falls[$];
  logic txd_b_d = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_state_a != 3'd0) a_nonidle <= a_nonidle + 1;
    if (rx_state_a == 3'd1) a_start <= a_start + 1;
    if (rx_state_a == 3'd2) a_data <= a_data + 1;
    if (!txd_a) a_txd_low <= a_txd_low + 1;
    if (if_b.rx_overrun) b_ovr <= b_ovr + 1;
    if (txd_b_d && !txd_b) b_falls.push_back(cyc);
    txd_b_d <= txd_b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_a(input logic [7:0] d);
    @(negedge clk);
    check("a_tx_ready", 32'(if_a.tx_ready), 1);
    if_a.tx_data = d; if_a.tx_valid = 1'b1;
    @(posedge clk); #1;
    if_a.tx_valid = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    @(negedge clk);
    if_b.tx_data = d; if_b.tx_valid = 1'b1;
    @(posedge clk); #1;
    if_b.tx_valid = 1'b0;
  endtask

  // Bit-bangs one frame into dut_b: start, 8 data LSB first, parity, two stops, 20 cycles each.
  task automatic send_b(input logic [7:0] d, input logic p, input logic s1, input logic s2);
    logic [11:0] f;
    f = {s2, s1, p, d, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      rxd_b_drv = f[i];
      repeat (20) @(negedge clk);
    end
    rxd_b_drv = 1'b1;
  endtask

  // Called at a negedge; checks the head entry, then pops it.
  task automatic pop_b(input int idx, input logic [7:0] d, input logic pe, input logic fe);
    check($sformatf("pop%0d_valid", idx), 32'(if_b.rx_valid), 1);
    check($sformatf("pop%0d_data", idx), 32'(if_b.rx_data), 32'(d));
    check($sformatf("pop%0d_perr", idx), 32'(if_b.rx_perr), 32'(pe));
    check($sformatf("pop%0d_ferr", idx), 32'(if_b.rx_ferr), 32'(fe));
    if_b.rx_ready = 1'b1;
    @(posedge clk); #1;
    if_b.rx_ready = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] tx_byte;
    logic [7:0] d;
    int s0, s1, s2, t;

    if_a.rx_ready = 1'b0; if_a.tx_valid = 1'b0; if_a.tx_data = 8'h00;
    if_b.rx_ready = 1'b0; if_b.tx_valid = 1'b0; if_b.tx_data = 8'h00;
    rxd_a = 1'b1; rxd_b_drv = 1'b1; loop_b = 1'b0;
    baud_div_a = 16'd0; baud_div_b = 16'd20;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd_a", 32'(txd_a), 1);
    check("rst_rx_valid_a", 32'(if_a.rx_valid), 0);
    check("rst_overrun_a", 32'(if_a.rx_overrun), 0);
    check("rst_tx_ready_a", 32'(if_a.tx_ready), 1);
    check("rst_tx_idle_a", 32'(if_a.tx_idle), 1);
    check("rst_txd_b", 32'(txd_b), 1);
    check("rst_rx_valid_b", 32'(if_b.rx_valid), 0);
    rst_ = 1'b1;
    repeat (5) @(negedge clk);

    // TX frame timing, D=100: accept at edge N, start bit from N+2
    tx_byte = 8'hA5;
    push_a(tx_byte);
    @(negedge clk);
    check("tx_n0_txd", 32'(txd_a), 1);
    @(negedge clk);
    check("tx_n1_txd", 32'(txd_a), 1);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      logic exp_bit;
      exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : tx_byte[k-1];
      check($sformatf("tx_bit%0d_first", k), 32'(txd_a), 32'(exp_bit));
      repeat (99) @(negedge clk);
      check($sformatf("tx_bit%0d_last", k), 32'(txd_a), 32'(exp_bit));
      @(negedge clk);
    end
    check("tx_after_idle", 32'(if_a.tx_idle), 1);
    check("tx_after_txd", 32'(txd_a), 1);

    // Glitch filter: 10-cycle pulse ignored, 40-cycle pulse is a false start
    repeat (20) @(negedge clk);
    s0 = a_nonidle;
    rxd_a = 1'b0;
    repeat (10) @(negedge clk);
    rxd_a = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch10_no_activity", 32'(a_nonidle - s0), 0);
    s1 = a_start; s2 = a_data;
    rxd_a = 1'b0;
    repeat (40) @(negedge clk);
    rxd_a = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch40_started", 32'(a_start - s1 > 0), 1);
    check("glitch40_no_data", 32'(a_data - s2), 0);
    check("glitch40_back_idle", 32'(rx_state_a), 0);
    check("glitch40_no_push", 32'(if_a.rx_valid), 0);

    // Loopback, even parity, two stops, D=20: frames are 12x20 cycles
    loop_b = 1'b1;
    repeat (5) @(negedge clk);
    push_b(8'h00);
    push_b(8'hFF);
    push_b(8'h3C);
    @(negedge clk);
    t = 0;
    while (!if_b.tx_idle && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("loop_tx_done", 32'(if_b.tx_idle), 1);
    repeat (60) @(negedge clk);
    loop_b = 1'b0;
    // Falling edges: 0x00 start, 0xFF start, 0xFF parity bit, 0x3C start, 0x3C bit6
    check("loop_fall_count", 32'(b_falls.size()), 5);
    if (b_falls.size() == 5) begin
      check("loop_frame1_start", 32'(b_falls[1] - b_falls[0]), 240);
      check("loop_frame1_parity", 32'(b_falls[2] - b_falls[0]), 420);
      check("loop_frame2_start", 32'(b_falls[3] - b_falls[0]), 480);
      check("loop_frame2_bit6", 32'(b_falls[4] - b_falls[0]), 620);
    end
    pop_b(0, 8'h00, 1'b0, 1'b0);
    pop_b(1, 8'hFF, 1'b0, 1'b0);
    pop_b(2, 8'h3C, 1'b0, 1'b0);
    check("loop_drained", 32'(if_b.rx_valid), 0);

    // Parity error frame, then framing error frame
    send_b(8'h55, 1'b1, 1'b1, 1'b1);
    send_b(8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (30) @(negedge clk);
    pop_b(3, 8'h55, 1'b1, 1'b0);
    pop_b(4, 8'h3C, 1'b0, 1'b1);
    check("err_drained", 32'(if_b.rx_valid), 0);

    // Overrun: 17 frames into a 16-deep FIFO with no pops
    s0 = b_ovr;
    for (int i = 0; i < 17; i++) begin
      d = 8'(16 + i);
      send_b(d, ^d, 1'b1, 1'b1);
    end
    repeat (30) @(negedge clk);
    check("ovr_valid", 32'(if_b.rx_valid), 1);
    check("ovr_head", 32'(if_b.rx_data), 32'h10);
    check("ovr_pulses", 32'(b_ovr - s0), 1);
    for (int i = 0; i < 16; i++) begin
      d = 8'(16 + i);
      pop_b(5 + i, d, 1'b0, 1'b0);
    end
    check("ovr_last_lost", 32'(if_b.rx_valid), 0);

    // Asynchronous reset in the middle of a TX data bit
    push_a(8'h5A);
    repeat (350) @(negedge clk);
    #2 rst_ = 1'b0;
    #1;
    check("rst_mid_txd", 32'(txd_a), 1);
    check("rst_mid_idle", 32'(if_a.tx_idle), 1);
    check("rst_mid_ready", 32'(if_a.tx_ready), 1);
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    s0 = a_txd_low;
    repeat (1200) @(negedge clk);
    check("rst_after_no_frame", 32'(a_txd_low - s0), 0);
    check("rst_after_idle", 32'(if_a.tx_idle), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
